// File: rtl/binary_gcd_core.sv
// -----------------------------------------------------------------------------
// find_first_one
//   Returns the bit index of the lowest set bit of in_i. With FLIP=1 the input
//   vector is bit-reversed first, so the index counts from the MSB side instead
//   (a leading-zero count). Purely combinational.
// Ports:
//   in_i         in   WIDTH          vector to scan
//   first_one_o  out  clog2(WIDTH)   index of first set bit (0 when none)
//   no_ones_o    out  1              in_i is all zeros
// -----------------------------------------------------------------------------
module find_first_one #(
   parameter int WIDTH = 32,
   parameter bit FLIP  = 1'b0
) (
   input  logic [WIDTH-1:0]         in_i,
   output logic [$clog2(WIDTH)-1:0] first_one_o,
   output logic                     no_ones_o
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] scan_vec;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_flip
         if (FLIP) begin : g_rev
            assign scan_vec[gi] = in_i[WIDTH-1-gi];
         end else begin : g_fwd
            assign scan_vec[gi] = in_i[gi];
         end
      end
   endgenerate

   // Scanning from the top down lets the lowest set bit be the last writer.
   always_comb begin
      first_one_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (scan_vec[i]) first_one_o = i[CW-1:0];
      end
   end

   assign no_ones_o = ~|scan_vec;
endmodule

// -----------------------------------------------------------------------------
// binary_gcd_core
//   Iterative Stein (binary) GCD engine for unsigned WIDTH-bit operands.
//   IDLE accepts an operand pair; NORM strips the common and individual powers
//   of two in one cycle; REDUCE performs one subtract-and-strip step per cycle
//   until both operands agree; DONE presents the result until the sink takes it.
// Ports:
//   clk_i        in   1      clock, rising edge
//   rst_ni       in   1      synchronous active-low reset
//   a_i, b_i     in   WIDTH  operands (sampled only on accept in IDLE)
//   in_valid_i   in   1      operand pair valid
//   in_ready_o   out  1      high only in IDLE (registered)
//   gcd_o        out  WIDTH  result, holds the last value when not valid
//   out_valid_o  out  1      high only in DONE (registered)
//   out_ready_i  in   1      sink accepts result
// -----------------------------------------------------------------------------
module binary_gcd_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] gcd_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_NORM   = 2'd1,
      ST_REDUCE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [CW-1:0]    k_reg;
   logic [WIDTH-1:0] gcd_reg;
   logic             out_valid_reg;
   logic             in_ready_reg;

   // Difference of the two odd operands; always even and nonzero in REDUCE.
   logic             a_gt_b;
   logic [WIDTH-1:0] diff;

   // Two trailing-zero counters shared across states:
   //   IDLE   : raw inputs, only the all-zero flags are used (fast path)
   //   NORM   : a_reg and b_reg individually
   //   REDUCE : counter A looks at the difference
   logic [WIDTH-1:0] ctz_a_in;
   logic [WIDTH-1:0] ctz_b_in;
   logic [CW-1:0]    ctz_a;
   logic [CW-1:0]    ctz_b;
   logic             a_zero;
   logic             b_zero;
   logic [CW-1:0]    ctz_min;

   assign a_gt_b = a_reg > b_reg;
   assign diff   = a_gt_b ? (a_reg - b_reg) : (b_reg - a_reg);

   always_comb begin
      ctz_a_in = diff;
      ctz_b_in = b_reg;
      case (state_reg)
         ST_IDLE: begin
            ctz_a_in = a_i;
            ctz_b_in = b_i;
         end
         ST_NORM: begin
            ctz_a_in = a_reg;
            ctz_b_in = b_reg;
         end
         default: begin
            ctz_a_in = diff;
            ctz_b_in = b_reg;
         end
      endcase
   end

   find_first_one #(.WIDTH(WIDTH), .FLIP(1'b0)) u_ctz_a (
      .in_i        (ctz_a_in),
      .first_one_o (ctz_a),
      .no_ones_o   (a_zero)
   );

   find_first_one #(.WIDTH(WIDTH), .FLIP(1'b0)) u_ctz_b (
      .in_i        (ctz_b_in),
      .first_one_o (ctz_b),
      .no_ones_o   (b_zero)
   );

   // ctz(a|b) equals the smaller of the two individual trailing-zero counts,
   // so the shared power of two needs no third counter.
   assign ctz_min = (ctz_a < ctz_b) ? ctz_a : ctz_b;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg     <= ST_IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         k_reg         <= '0;
         gcd_reg       <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid_i) begin
                  a_reg        <= a_i;
                  b_reg        <= b_i;
                  in_ready_reg <= 1'b0;
                  if (a_zero || b_zero) begin
                     // gcd(0,x)=x and gcd(0,0)=0
                     gcd_reg       <= a_i | b_i;
                     out_valid_reg <= 1'b1;
                     state_reg     <= ST_DONE;
                  end else begin
                     state_reg <= ST_NORM;
                  end
               end
            end
            ST_NORM: begin
               k_reg     <= ctz_min;
               a_reg     <= a_reg >> ctz_a;
               b_reg     <= b_reg >> ctz_b;
               state_reg <= ST_REDUCE;
            end
            ST_REDUCE: begin
               if (a_reg == b_reg) begin
                  gcd_reg       <= a_reg << k_reg;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_DONE;
               end else if (a_gt_b) begin
                  a_reg <= diff >> ctz_a;
               end else begin
                  b_reg <= diff >> ctz_a;
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_reg;
   assign out_valid_o = out_valid_reg;
   assign gcd_o       = gcd_reg;
endmodule

// File: tb/tb_binary_gcd_core.sv
// Testbench for binary_gcd_core: directed vector table, hand-written
// backpressure and reset sequences, then randomized pairs against a
// Euclid-based reference model.
module tb_binary_gcd_core;
   localparam int W      = 32;
   localparam int MAXLAT = 2 * W + 2;

   logic         clk_i       = 1'b0;
   logic         rst_ni      = 1'b0;
   logic [W-1:0] a_i         = '0;
   logic [W-1:0] b_i         = '0;
   logic         in_valid_i  = 1'b0;
   logic         out_ready_i = 1'b0;
   logic         in_ready_o;
   logic [W-1:0] gcd_o;
   logic         out_valid_o;

   int n_vec = 0;
   int n_bad = 0;

   binary_gcd_core #(.WIDTH(W)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .a_i         (a_i),
      .b_i         (b_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .gcd_o       (gcd_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;   // edges after accept until out_valid; -1 = unchecked
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Euclid by remainder: independent of the binary algorithm in the DUT.
   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x[W-1:0];
   endfunction

   // Called #1 after a rising edge. Waits for ready, issues one pair, and
   // returns once out_valid_o is seen (lat = edges after the accept edge).
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat, output bit ok);
      ok  = 1'b0;
      res = '0;
      lat = -1;
      for (int i = 0; i < 8 && !in_ready_o; i++) begin
         @(posedge clk_i);
         #1;
      end
      if (!in_ready_o) begin
         n_vec++;
         n_bad++;
         $display("FAIL ready_timeout: in_ready_o=%0b, expected 1", in_ready_o);
         return;
      end
      a_i        = a;
      b_i        = b;
      in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      a_i        = $urandom;
      b_i        = $urandom;
      lat        = 0;
      while (!out_valid_o && lat <= MAXLAT) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      if (!out_valid_o) begin
         n_vec++;
         n_bad++;
         $display("FAIL result_timeout: a=%0h b=%0h no out_valid_o within %0d cycles", a, b, MAXLAT);
         return;
      end
      res = gcd_o;
      ok  = 1'b1;
   endtask

   // Holds the result for 'hold' cycles checking stability, then hands it off.
   task automatic drain(input int hold, input logic [W-1:0] exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i);
         #1;
         check("hold_valid", W'(out_valid_o), W'(1));
         check("hold_gcd", gcd_o, exp);
      end
      out_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
      check("drain_in_ready", W'(in_ready_o), W'(1));
      check("drain_out_valid", W'(out_valid_o), W'(0));
   endtask

   initial begin
      logic [W-1:0] res, ra, rb, exp;
      int           lat;
      bit           ok;

      tbl[0] = '{32'd48,         32'd18,         32'd6,          3};
      tbl[1] = '{32'd0,          32'd0,          32'd0,          0};
      tbl[2] = '{32'd0,          32'd35,         32'd35,         0};
      tbl[3] = '{32'd1000,       32'd0,          32'd1000,       0};
      tbl[4] = '{32'h8000_0000,  32'hC000_0000,  32'h4000_0000,  3};
      tbl[5] = '{32'd17,         32'd5,          32'd1,          5};
      tbl[6] = '{32'd12,         32'd8,          32'd4,          3};
      tbl[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  2};
      tbl[8] = '{32'd1,          32'hFFFF_FFFF,  32'd1,          -1};
      tbl[9] = '{32'h0070_0000,  32'h0050_0000,  32'h0010_0000,  4};

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_in_ready", W'(in_ready_o), W'(1));
      check("rst_out_valid", W'(out_valid_o), W'(0));
      check("rst_gcd", gcd_o, '0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         issue(tbl[i].a, tbl[i].b, res, lat, ok);
         if (ok) begin
            $display("vec %0d: a=%0h b=%0h gcd=%0h lat=%0d", i, tbl[i].a, tbl[i].b, res, lat);
            check($sformatf("tbl%0d_gcd", i), res, tbl[i].exp);
            if (tbl[i].lat >= 0)
               check($sformatf("tbl%0d_lat", i), W'(lat), W'(tbl[i].lat));
            drain(0, tbl[i].exp);
         end
      end

      // Backpressure: hold DONE for 5 cycles and pulse in_valid_i meanwhile
      issue(32'd360, 32'd84, res, lat, ok);
      if (ok) begin
         $display("bp: a=360 b=84 gcd=%0h", res);
         check("bp_gcd", res, 32'd12);
         for (int i = 0; i < 5; i++) begin
            in_valid_i = (i == 2);
            a_i        = 32'd5;
            b_i        = 32'd10;
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
            check("bp_valid", W'(out_valid_o), W'(1));
            check("bp_in_ready", W'(in_ready_o), W'(0));
            check("bp_gcd_stable", gcd_o, 32'd12);
         end
         drain(0, 32'd12);
         repeat (2) begin
            @(posedge clk_i);
            #1;
            check("bp_ignored_valid", W'(out_valid_o), W'(0));
            check("bp_idle_ready", W'(in_ready_o), W'(1));
         end
      end

      // Reset in the middle of REDUCE for (17,5)
      a_i        = 32'd17;
      b_i        = 32'd5;
      in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      repeat (2) begin
         @(posedge clk_i);
         #1;
      end
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      $display("mid-reduce reset: in_ready=%0b out_valid=%0b gcd=%0h", in_ready_o, out_valid_o, gcd_o);
      check("mr_in_ready", W'(in_ready_o), W'(1));
      check("mr_out_valid", W'(out_valid_o), W'(0));
      check("mr_gcd", gcd_o, '0);
      @(posedge clk_i);
      #1;
      check("mr_discarded", W'(out_valid_o), W'(0));
      issue(32'd12, 32'd8, res, lat, ok);
      if (ok) begin
         $display("post-reset: a=12 b=8 gcd=%0h", res);
         check("mr_next_gcd", res, 32'd4);
         drain(0, 32'd4);
      end

      // Randomized pairs against the reference model
      for (int n = 0; n < 1000; n++) begin
         case ($urandom_range(0, 5))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = $urandom; rb = ra; end
            2: begin ra = 32'd1 << $urandom_range(0, W-1); rb = 32'd1 << $urandom_range(0, W-1); end
            3: begin ra = 32'hFFFF_FFFF; rb = $urandom; end
            4: begin ra = $urandom_range(0, 1) ? 32'd0 : 32'($urandom); rb = $urandom_range(0, 3); end
            default: begin
               ra = 32'($urandom_range(1, 4095)) << $urandom_range(0, 16);
               rb = 32'($urandom_range(1, 4095)) << $urandom_range(0, 16);
            end
         endcase
         exp = ref_gcd(ra, rb);
         issue(ra, rb, res, lat, ok);
         if (ok) begin
            $display("rnd %0d: a=%0h b=%0h gcd=%0h exp=%0h lat=%0d", n, ra, rb, res, exp, lat);
            check("rnd_gcd", res, exp);
            check("rnd_lat_bound", W'(lat <= MAXLAT), W'(1));
            drain($urandom_range(0, 2), exp);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
